// File: rtl/cam_sccb_master_pkg.sv
`default_nettype none
//==============================================================================
// Package  : cam_sccb_pkg
// Brief    : Shared types and field positions for the SCCB command engine.
// Revision : 1.0
//==============================================================================
package cam_sccb_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_BIT   = 3'd2,
    S_ACK   = 3'd3,
    S_STOP  = 3'd4,
    S_GAP   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam int CMD_RD      = 31;
  localparam int CMD_ADDR_HI = 23;
  localparam int CMD_ADDR_LO = 8;

  localparam int RESP_NACK = 17;
  localparam int RESP_DROP = 16;

  // Byte slots of a transaction; the read second half resumes at BYTE_ID_R.
  localparam logic [2:0] BYTE_ID_W    = 3'd0;
  localparam logic [2:0] BYTE_ADDR_HI = 3'd1;
  localparam logic [2:0] BYTE_ADDR_LO = 3'd2;
  localparam logic [2:0] BYTE_DATA    = 3'd3;
  localparam logic [2:0] BYTE_ID_R    = 3'd4;
  localparam logic [2:0] BYTE_RX      = 3'd5;

endpackage
`default_nettype wire

// File: rtl/cam_sccb_master_if.sv
`default_nettype none
//==============================================================================
// Interface : cam_sccb_master_if
// Brief     : Command/response and SCL/SDA pin bundle of one camera port.
// Revision  : 1.0
//==============================================================================
interface cam_sccb_master_if;
  logic [31:0] cmd;
  logic        cmd_valid;
  logic [17:0] resp;
  logic        resp_valid;
  logic        busy;
  logic        scl;
  logic        sda_oe;
  logic        sda_i;

  modport master (
    input  cmd, cmd_valid, sda_i,
    output resp, resp_valid, busy, scl, sda_oe
  );

  modport slave (
    output cmd, cmd_valid, sda_i,
    input  resp, resp_valid, busy, scl, sda_oe
  );
endinterface
`default_nettype wire

// File: rtl/cam_sccb_qtick.sv
`default_nettype none
//==============================================================================
// Module   : cam_sccb_qtick
// Brief    : Quarter-period divider; q index and quarter-end pulse while enabled.
// Revision : 1.0
//==============================================================================
module cam_sccb_qtick #(
  parameter int QDIV = 250
) (
  input  wire        fclk,
  input  wire        rst,
  input  wire        i_en,
  output logic [1:0] o_q,
  output logic       o_qend
);
  localparam int CW = $clog2(QDIV);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_q;
  logic          w_last;

  assign w_last = (r_cnt == CW'(QDIV - 1));

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_q   <= 2'd0;
    end else if (!i_en) begin
      r_cnt <= '0;
      r_q   <= 2'd0;
    end else if (w_last) begin
      r_cnt <= '0;
      r_q   <= r_q + 2'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_q    = r_q;
  assign o_qend = i_en & w_last;
endmodule
`default_nettype wire

// File: rtl/cam_sccb_master.sv
`default_nettype none
//==============================================================================
// Module   : cam_sccb_master
// Brief    : SCCB register write/read engine driven by one camera command word.
// Revision : 1.0
//==============================================================================
module cam_sccb_master
  import cam_sccb_pkg::*;
#(
  parameter int         QDIV   = 250,
  parameter logic [7:0] DEV_ID = 8'h78
) (
  input wire                fclk,
  input wire                rst,
  cam_sccb_master_if.master bus
);
  state_t      r_state, w_next;
  logic        r_vld_d, r_rd, r_ack, r_nack, r_drop;
  logic [15:0] r_addr;
  logic [7:0]  r_data, r_shift, r_rx, w_tx_byte;
  logic [2:0]  r_byte, r_bitcnt, w_tx_sel;
  logic [17:0] r_resp;
  logic [1:0]  w_q;
  logic        w_qend, w_pend, w_samp, w_busy, w_rise, w_accept, w_drop_set;
  logic        w_rx_byte, w_ack_stop, w_gap, w_load_resp, w_scl, w_sda_oe;
  logic        w_unused;

  cam_sccb_qtick #(.QDIV(QDIV)) u_qtick (
    .fclk   (fclk),
    .rst    (rst),
    .i_en   (w_busy),
    .o_q    (w_q),
    .o_qend (w_qend)
  );

  assign w_busy      = (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_rise      = bus.cmd_valid & ~r_vld_d;
  assign w_accept    = w_rise & ~w_busy;
  assign w_drop_set  = w_rise & w_busy;
  assign w_pend      = w_qend && (w_q == 2'd3);
  assign w_samp      = w_qend && (w_q == 2'd2);
  assign w_rx_byte   = (r_byte == BYTE_RX);
  assign w_ack_stop  = w_rx_byte | r_ack | (r_rd ? (r_byte == BYTE_ADDR_LO) : (r_byte == BYTE_DATA));
  assign w_gap       = r_rd && !r_nack && (r_byte == BYTE_ADDR_LO);
  assign w_load_resp = (r_state == S_STOP) && w_pend && !w_gap;
  assign w_tx_sel    = (r_state == S_ACK) ? r_byte + 3'd1 : r_byte;
  assign w_unused    = &{1'b0, bus.cmd[30:24], DEV_ID[0]};

  always_comb begin
    w_tx_byte = 8'hFF;
    case (w_tx_sel)
      BYTE_ID_W:    w_tx_byte = {DEV_ID[7:1], 1'b0};
      BYTE_ADDR_HI: w_tx_byte = r_addr[15:8];
      BYTE_ADDR_LO: w_tx_byte = r_addr[7:0];
      BYTE_DATA:    w_tx_byte = r_data;
      BYTE_ID_R:    w_tx_byte = {DEV_ID[7:1], 1'b1};
      default:      w_tx_byte = 8'hFF;
    endcase
  end

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_scl    = 1'b1;
    w_sda_oe = 1'b0;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_next = S_START;
      S_START: begin
        w_scl    = (w_q != 2'd3);
        w_sda_oe = w_q[1];
        if (w_pend) w_next = S_BIT;
      end
      S_BIT: begin
        w_scl    = w_q[1];
        w_sda_oe = !w_rx_byte && !r_shift[7];
        if (w_pend && (r_bitcnt == 3'd7)) w_next = S_ACK;
      end
      S_ACK: begin
        w_scl = w_q[1];
        if (w_pend) w_next = w_ack_stop ? S_STOP : S_BIT;
      end
      S_STOP: begin
        w_scl    = (w_q != 2'd0);
        w_sda_oe = !w_q[1];
        if (w_pend) w_next = w_gap ? S_GAP : S_DONE;
      end
      S_GAP:   if (w_pend) w_next = S_START;
      S_DONE:  w_next = w_accept ? S_START : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      r_vld_d  <= 1'b0;
      r_rd     <= 1'b0;
      r_addr   <= 16'h0000;
      r_data   <= 8'h00;
      r_byte   <= BYTE_ID_W;
      r_bitcnt <= 3'd0;
      r_shift  <= 8'hFF;
      r_rx     <= 8'h00;
      r_ack    <= 1'b0;
      r_nack   <= 1'b0;
      r_drop   <= 1'b0;
      r_resp   <= 18'h00000;
    end else begin
      r_vld_d <= bus.cmd_valid;
      // A drop arriving as a response loads stays pending for the next one.
      if (w_drop_set)       r_drop <= 1'b1;
      else if (w_load_resp) r_drop <= 1'b0;
      if (w_accept) begin
        r_rd   <= bus.cmd[CMD_RD];
        r_addr <= bus.cmd[CMD_ADDR_HI:CMD_ADDR_LO];
        r_data <= bus.cmd[7:0];
        r_byte <= BYTE_ID_W;
        r_nack <= 1'b0;
        r_rx   <= 8'h00;
      end
      if (w_samp) begin
        if ((r_state == S_BIT) && w_rx_byte) r_rx  <= {r_rx[6:0], bus.sda_i};
        if (r_state == S_ACK)                r_ack <= bus.sda_i;
      end
      if (w_pend) begin
        case (r_state)
          S_START: begin
            r_shift  <= w_tx_byte;
            r_bitcnt <= 3'd0;
          end
          S_BIT: begin
            r_shift  <= {r_shift[6:0], 1'b0};
            r_bitcnt <= r_bitcnt + 3'd1;
          end
          S_ACK: begin
            if (r_ack && !w_rx_byte) r_nack <= 1'b1;
            if (!w_ack_stop) begin
              r_byte   <= r_byte + 3'd1;
              r_shift  <= w_tx_byte;
              r_bitcnt <= 3'd0;
            end
          end
          S_STOP:  if (w_gap) r_byte <= BYTE_ID_R;
          default: ;
        endcase
      end
      if (w_load_resp) r_resp <= {r_nack, r_drop, r_addr[7:0], r_rx};
    end
  end

  assign bus.resp       = r_resp;
  assign bus.resp_valid = (r_state == S_DONE);
  assign bus.busy       = w_busy;
  assign bus.scl        = w_scl;
  assign bus.sda_oe     = w_sda_oe;
endmodule
`default_nettype wire

// File: tb/tb_cam_sccb_master.sv
`default_nettype none
//==============================================================================
// Module   : tb_cam_sccb_master
// Brief    : Bench with an SCCB sensor model and transaction-level reference.
// Revision : 1.0
//==============================================================================
module tb_cam_sccb_master;
  localparam int Q     = 2;
  localparam int LIMIT = 4 * Q * 60;

  logic fclk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  cam_sccb_master_if bus ();

  cam_sccb_master #(.QDIV(Q), .DEV_ID(8'h78)) dut (
    .fclk (fclk),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 fclk = ~fclk;

  logic s_drive = 1'b0;
  assign bus.sda_i = ~(bus.sda_oe | s_drive);

  logic [7:0] log_b[$];
  logic       log_a[$];
  int         n_start = 0, n_stop = 0;
  int         nack_at = -1, txn_bytes = 0;
  logic [7:0] rdata_model = 8'h00;
  int         mbits = 0, since_start = 0, cnt = 0, lo_len = 0, hi_len = 0;
  logic       rd_mode = 1'b0, ss = 1'b0, prev_data = 1'b0, prev_scl = 1'b1, prev_sda = 1'b1;
  logic [7:0] sh = 8'h00;
  logic       b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus decoder plus sensor: acks written bytes, returns rdata_model on reads.
  always @(negedge fclk) begin
    if (rst) begin
      s_drive = 1'b0; mbits = 0; since_start = 0; rd_mode = 1'b0; ss = 1'b0;
      prev_data = 1'b0; cnt = 0; prev_scl = 1'b1; prev_sda = 1'b1;
    end else begin
      if (bus.scl && prev_scl && (bus.sda_i != prev_sda)) begin
        ss = 1'b1;
        if (!bus.sda_i) begin n_start++; mbits = 0; since_start = 0; rd_mode = 1'b0; end
        else begin n_stop++; s_drive = 1'b0; end
      end
      if (bus.scl != prev_scl) begin
        if (bus.scl) lo_len = cnt;
        else begin
          hi_len = cnt;
          if (!ss) begin
            chk("scl_high_len", 32'(hi_len), 32'(2 * Q));
            if (prev_data) chk("scl_low_len", 32'(lo_len), 32'(2 * Q));
            prev_data = 1'b1;
            b = prev_sda;
            if (mbits < 8) begin
              sh = {sh[6:0], b};
              mbits++;
            end else begin
              log_b.push_back(sh);
              log_a.push_back(b);
              if (since_start == 0) rd_mode = sh[0] && !b;
              since_start++;
              mbits = 0;
            end
            s_drive = 1'b0;
            if (rd_mode && since_start == 1) begin
              if (mbits < 8) s_drive = ~rdata_model[3'(7 - mbits)];
            end else if (mbits == 8) begin
              s_drive = (txn_bytes != nack_at);
              txn_bytes++;
            end
          end else begin
            prev_data = 1'b0;
          end
          ss = 1'b0;
        end
        cnt = 1;
      end else begin
        cnt++;
      end
      prev_scl = bus.scl;
      prev_sda = bus.sda_i;
    end
  end

  task automatic run_cmd(input logic rd, input logic [15:0] addr, input logic [7:0] data,
                         input logic [7:0] rdat, input int nk, input int hold, input logic drop_edge);
    logic [7:0] wb[4];
    logic [7:0] eb[$];
    logic       ea[$];
    logic       nacked;
    int         phases, exp_cyc, exp_ss, base, s0, p0, cyc;
    logic [17:0] exp_resp;
    wb[0] = 8'h78; wb[1] = addr[15:8]; wb[2] = addr[7:0]; wb[3] = rd ? 8'h79 : data;
    nacked = 1'b0;
    for (int i = 0; i < 4; i++) begin
      eb.push_back(wb[i]);
      ea.push_back(i == nk);
      if (i == nk) begin nacked = 1'b1; break; end
    end
    if (rd && !nacked) begin eb.push_back(rdat); ea.push_back(1'b1); end
    if (!rd)                  phases = 2 + 9 * eb.size();
    else if (nacked && nk < 3) phases = 2 + 9 * (nk + 1);
    else                      phases = 1 + 27 + 3 + 9 + (nacked ? 0 : 9) + 1;
    exp_cyc  = 4 * Q * phases + 1;
    exp_ss   = (rd && !(nacked && nk < 3)) ? 2 : 1;
    exp_resp = {nacked, drop_edge, addr[7:0], (rd && !nacked) ? rdat : 8'h00};

    base = log_b.size(); s0 = n_start; p0 = n_stop;
    nack_at = nk; rdata_model = rdat; txn_bytes = 0;
    @(negedge fclk);
    bus.cmd = {rd, 7'($urandom), addr, data};
    bus.cmd_valid = 1'b1;
    cyc = 0;
    while (cyc < LIMIT) begin
      @(negedge fclk);
      cyc++;
      if (cyc == hold) bus.cmd_valid = 1'b0;
      if (cyc == 1) chk("busy_after_accept", 32'(bus.busy), 32'd1);
      if (drop_edge && cyc == 20) bus.cmd_valid = 1'b1;
      if (drop_edge && cyc == 22) bus.cmd_valid = 1'b0;
      if (bus.resp_valid) break;
    end
    chk("latency", 32'(cyc), 32'(exp_cyc));
    chk("resp", 32'(bus.resp), 32'(exp_resp));
    @(negedge fclk);
    chk("resp_valid_once", 32'(bus.resp_valid), 32'd0);
    chk("busy_idle", 32'(bus.busy), 32'd0);
    chk("byte_count", 32'(log_b.size() - base), 32'(eb.size()));
    for (int i = 0; i < eb.size() && base + i < log_b.size(); i++) begin
      chk("bus_byte", 32'(log_b[base + i]), 32'(eb[i]));
      chk("bus_ack", 32'(log_a[base + i]), 32'(ea[i]));
    end
    chk("start_count", 32'(n_start - s0), 32'(exp_ss));
    chk("stop_count", 32'(n_stop - p0), 32'(exp_ss));
  endtask

  initial begin
    logic rv_seen;
    int   nk;
    rst = 1'b1;
    bus.cmd = 32'h0;
    bus.cmd_valid = 1'b0;
    repeat (3) @(negedge fclk);
    chk("rst_scl", 32'(bus.scl), 32'd1);
    chk("rst_sda_oe", 32'(bus.sda_oe), 32'd0);
    chk("rst_resp", 32'(bus.resp), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;

    run_cmd(1'b0, 16'h3008, 8'h11, 8'h00, -1, 3, 1'b0);
    run_cmd(1'b1, 16'h300A, 8'h00, 8'h56, -1, 1, 1'b0);
    run_cmd(1'b0, 16'h1234, 8'hA5, 8'h00, 1, 2, 1'b0);
    run_cmd(1'b0, 16'h4455, 8'h66, 8'h00, -1, 1, 1'b1);
    run_cmd(1'b1, 16'h0102, 8'h00, 8'h9C, -1, 2, 1'b0);

    @(negedge fclk);
    bus.cmd = 32'h0012_3455;
    bus.cmd_valid = 1'b1;
    repeat (60) @(negedge fclk);
    chk("busy_mid_byte", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_scl", 32'(bus.scl), 32'd1);
    chk("midrst_sda_oe", 32'(bus.sda_oe), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    bus.cmd_valid = 1'b0;
    rv_seen = bus.resp_valid;
    repeat (4) begin @(negedge fclk); if (bus.resp_valid) rv_seen = 1'b1; end
    rst = 1'b0;
    repeat (20) begin @(negedge fclk); if (bus.resp_valid) rv_seen = 1'b1; end
    chk("midrst_no_resp", 32'(rv_seen), 32'd0);
    run_cmd(1'b0, 16'hBEEF, 8'h5A, 8'h00, -1, 4, 1'b0);

    for (int i = 0; i < 8; i++) begin
      nk = int'($urandom_range(0, 7));
      if (nk > 3) nk = -1;
      run_cmd(1'($urandom), 16'($urandom), 8'($urandom), 8'($urandom), nk,
              int'($urandom_range(1, 4)), 1'($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
